// File: rtl/rx_control.sv
`default_nettype none
// ============================================================================
// Module   : rx_control
// Purpose  : SPART receive path. Synchronises the asynchronous serial line,
//            oversamples it with the shared baud-rate enable, frames 8N1
//            characters (optionally with an even-parity bit) and holds the
//            last received byte together with its status flags for the
//            processor bus.
// Ports    : clk, rst_n (synchronous, active-low)
//            rxd                 - serial input, idle high
//            brg_en              - one-cycle oversample enable
//            ioaddr/iorw/iocs    - bus decode; a read of address 0 clears
//                                  rda and overrun
//            rx_data             - receive buffer
//            rda                 - receive data available
//            framing_err         - last character had stop bit = 0
//            parity_err          - last character had bad parity
//            overrun             - a character overwrote an unread buffer
//            busy                - receiver is not in IDLE
// Options  : RX_PARITY_EN - when defined, one even-parity bit is expected
//            between the data and stop bits; otherwise parity_err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module rx_control #(
    parameter int SAMPLE_RATE = 16,
    parameter int NUM_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rxd,
    input  logic                brg_en,
    input  logic [1:0]          ioaddr,
    input  logic                iorw,
    input  logic                iocs,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                rda,
    output logic                framing_err,
    output logic                parity_err,
    output logic                overrun,
    output logic                busy
);

    localparam int SW = $clog2(SAMPLE_RATE + 1);
    localparam int BW = $clog2(NUM_BITS + 1);

    localparam logic [SW-1:0] SAMP_HALF = SW'(SAMPLE_RATE / 2);
    localparam logic [SW-1:0] SAMP_FULL = SW'(SAMPLE_RATE);
    localparam logic [BW-1:0] BITS_FULL = BW'(NUM_BITS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic                   rxs_d;
    logic                   start_edge;
    logic                   rd_strobe;
    logic [2:0]             state;
    logic [SW-1:0]          samp;
    logic [SW-1:0]          samp_inc;
    logic [BW-1:0]          bits;
    logic [BW-1:0]          bits_inc;
    logic [NUM_BITS-1:0]    shreg;
    logic                   half_tick;
    logic                   full_tick;
`ifdef RX_PARITY_EN
    logic                   par_err_q;
`endif

    // ------------------------------------------------------------------
    // Line synchroniser; flops reset to the idle (high) line level so a
    // reset never manufactures a start edge.
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES > 1) begin : g_sync_chain
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync <= '1;
                end else begin
                    sync <= {sync[SYNC_STAGES-2:0], rxd};
                end
            end
        end else begin : g_sync_single
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync <= '1;
                end else begin
                    sync <= rxd;
                end
            end
        end
    endgenerate

    assign rxs        = sync[SYNC_STAGES-1];
    assign start_edge = rxs_d & ~rxs;
    assign rd_strobe  = iocs & iorw & (ioaddr == 2'b00);
    assign samp_inc   = samp + 1'b1;
    assign bits_inc   = bits + 1'b1;
    assign half_tick  = brg_en & (samp_inc == SAMP_HALF);
    assign full_tick  = brg_en & (samp_inc == SAMP_FULL);
    assign busy       = (state != ST_IDLE);

`ifndef RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Framing FSM, counters, shift register and receive buffer.
    // The bus-read clear is written first so that a STOP load in the same
    // cycle overrides it (the load wins).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rxs_d       <= 1'b1;
            samp        <= '0;
            bits        <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_q   <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            rxs_d <= rxs;

            if (rd_strobe) begin
                rda     <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    samp <= '0;
                    bits <= '0;
                    // Edge (not level) detect: a held break after a framing
                    // error cannot restart reception.
                    if (start_edge) begin
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (half_tick) begin
                        samp <= '0;
                        bits <= '0;
                        // Line high at mid start bit: treat as a glitch.
                        state <= rxs ? ST_IDLE : ST_DATA;
                    end else if (brg_en) begin
                        samp <= samp_inc;
                    end
                end

                ST_DATA: begin
                    if (full_tick) begin
                        shreg <= {rxs, shreg[NUM_BITS-1:1]};
                        bits  <= bits_inc;
                        samp  <= '0;
                        if (bits_inc == BITS_FULL) begin
`ifdef RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else if (brg_en) begin
                        samp <= samp_inc;
                    end
                end

`ifdef RX_PARITY_EN
                ST_PARITY: begin
                    if (full_tick) begin
                        // Even parity: data plus parity bit must XOR to 0.
                        par_err_q <= ^{shreg, rxs};
                        samp      <= '0;
                        state     <= ST_STOP;
                    end else if (brg_en) begin
                        samp <= samp_inc;
                    end
                end
`endif

                ST_STOP: begin
                    if (full_tick) begin
                        rx_data     <= shreg;
                        rda         <= 1'b1;
                        framing_err <= ~rxs;
                        overrun     <= rda & ~rd_strobe;
`ifdef RX_PARITY_EN
                        parity_err  <= par_err_q;
`endif
                        samp        <= '0;
                        state       <= ST_IDLE;
                    end else if (brg_en) begin
                        samp <= samp_inc;
                    end
                end

                default: begin
                    samp  <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_control
// Purpose  : Self-checking bench for rx_control. Serial frames are generated
//            at 16 clk/bit with brg_en held high; a frame-level model of the
//            receive buffer and flags predicts the outputs after each event.
// Options  : RX_PARITY_EN - must match the RTL build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_control;

    localparam int SR = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       brg_en = 1'b1;
    logic [1:0] ioaddr = 2'b00;
    logic       iorw = 1'b0;
    logic       iocs = 1'b0;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Frame-level model of the receive buffer and status flags
    logic [7:0] m_data = 8'h00;
    logic       m_rda  = 1'b0;
    logic       m_fe   = 1'b0;
    logic       m_pe   = 1'b0;
    logic       m_ov   = 1'b0;

    rx_control #(
        .SAMPLE_RATE (16),
        .NUM_BITS    (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .brg_en      (brg_en),
        .ioaddr      (ioaddr),
        .iorw        (iorw),
        .iocs        (iocs),
        .rx_data     (rx_data),
        .rda         (rda),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".rx_data"}, 32'(rx_data), 32'(m_data));
        check({tag, ".rda"},     32'(rda),     32'(m_rda));
        check({tag, ".fe"},      32'(framing_err), 32'(m_fe));
        check({tag, ".pe"},      32'(parity_err),  32'(m_pe));
        check({tag, ".ov"},      32'(overrun), 32'(m_ov));
        check({tag, ".busy"},    32'(busy),    32'd0);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        wait_clk(n);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clk(SR);
    endtask

    // Full character: start, 8 data bits LSB first, optional parity, stop.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        send_bit(1'b0);
        check("busy_mid", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
        send_bit(par_b);
        m_pe = ^{d, par_b};
`else
        m_pe = 1'b0;
        if (par_b) begin end
`endif
        send_bit(stop_b);
        m_ov   = m_rda;
        m_rda  = 1'b1;
        m_data = d;
        m_fe   = ~stop_b;
    endtask

    // Bus access; only iocs & iorw & address 0 is a buffer read.
    task automatic bus_access(input logic [1:0] a, input logic rw);
        ioaddr = a;
        iorw   = rw;
        iocs   = 1'b1;
        wait_clk(1);
        iocs   = 1'b0;
        iorw   = 1'b0;
        ioaddr = 2'b00;
        if (a == 2'b00 && rw) begin
            m_rda = 1'b0;
            m_ov  = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       sb;
        logic       pb;

        // Reset state
        rst_n = 1'b0;
        wait_clk(3);
        check_state("reset");
        rst_n = 1'b1;
        idle(10);

        // Clean character with correct parity
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(4);
        check_state("a5");

        // Short glitch is rejected at the mid start bit
        rxd = 1'b0;
        wait_clk(4);
        idle(40);
        check_state("glitch");

        // Framing error followed by a long break: no second character
        send_frame(8'h3C, 1'b0, ^8'h3C);
        rxd = 1'b0;
        wait_clk(2);
        check_state("fe");
        wait_clk(40 * SR);
        check_state("break");
        idle(20);

        // Overrun then read
        bus_access(2'b00, 1'b1);
        send_frame(8'h11, 1'b1, ^8'h11);
        idle(5);
        send_frame(8'h22, 1'b1, ^8'h22);
        idle(5);
        check_state("ovr");
        bus_access(2'b00, 1'b1);
        check_state("ovr_rd");

        // Reset during data bit 4 discards the partial character
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_clk(5);
        rst_n = 1'b0;
        rxd   = 1'b1;
        wait_clk(1);
        rst_n  = 1'b1;
        m_data = 8'h00;
        m_rda  = 1'b0;
        m_fe   = 1'b0;
        m_pe   = 1'b0;
        m_ov   = 1'b0;
        check_state("midrst");
        idle(40);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle(4);
        check_state("after_rst");

`ifdef RX_PARITY_EN
        bus_access(2'b00, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        check_state("par_ok");
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        check_state("par_bad");
`endif

        // Randomised frames, glitches and bus traffic
        for (int n = 0; n < 40; n++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: bus_access(2'b00, 1'b1);
                1: bus_access(2'($urandom_range(1, 3)), 1'($urandom));
                2: begin
                    rxd = 1'b0;
                    wait_clk($urandom_range(1, 5));
                    idle(30);
                    check_state("rnd_glitch");
                end
                default: ;
            endcase
            idle($urandom_range(4, 20));
            send_frame(d, sb, pb);
            idle(4);
            check_state("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
